// File: rtl/synth_pkg.sv
// Shared constants for the guitar tone generator: widths, open-string MIDI notes
// and the string/fret half-period table derived from the clock frequency.
package synth_pkg;

  localparam int NSTR       = 6;
  localparam int NFRET      = 5;
  localparam int NFRET_W    = 3;
  localparam int HP_W       = 19;
  localparam int ENV_W      = 8;
  localparam int MIX_W      = 12;
  localparam int SAMPLE_W   = 24;
  localparam int DEF_CLK_HZ = 50_000_000;

  localparam int OPEN_MIDI [NSTR] = '{40, 45, 50, 55, 59, 64};

  typedef logic [NSTR-1:0][NFRET-1:0][HP_W-1:0] hp_table_t;

  // Equal-tempered pitch, rounded to the nearest whole clock per half period.
  function automatic hp_table_t build_hp_table(input int clk_hz);
    hp_table_t tab;
    real       freq;
    tab = '0;
    for (int s = 0; s < NSTR; s++) begin
      for (int f = 0; f < NFRET; f++) begin
        freq = 440.0 * (2.0 ** ((real'(OPEN_MIDI[s] + f) - 69.0) / 12.0));
        tab[s][f] = HP_W'($rtoi(real'(clk_hz) / (2.0 * freq) + 0.5));
      end
    end
    return tab;
  endfunction

  localparam hp_table_t HALF_PERIOD = build_hp_table(DEF_CLK_HZ);

endpackage

// File: rtl/string_osc.sv
// Square-wave oscillator for one string: toggles every half_period clocks while enabled.
// clear restarts the phase with the output high; a disabled string holds its phase at 0.
module string_osc
  import synth_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            sq
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            sq_q, sq_d;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (clear) begin
      cnt_d = '0;
      sq_d  = 1'b1;
    end else if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q >= half_period - HP_W'(1)) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
    end else begin
      cnt_d = cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/guitar_synth.sv
// Six-string square-wave synth: note word in, decaying mixed samples out every SAMPLE_DIV clocks.
// Sample is registered one cycle after the tick; a pending unaccepted sample is overwritten.
module guitar_synth
  import synth_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SAMPLE_DIV = 1042,
  parameter int DECAY_DIV  = 188
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [31:0]                note_in,
  input  logic                       note_strobe,
  input  logic                       play_en,
  input  logic                       sample_ready,
  output logic                       sample_write,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic [NSTR-1:0]            active_strings
);

  localparam int TK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam hp_table_t HP_TAB = (CLK_HZ == DEF_CLK_HZ) ? HALF_PERIOD : build_hp_table(CLK_HZ);

  typedef logic [NFRET_W-1:0] fret_t;

  logic [NSTR-1:0]            active_q, active_d, enc_act, sq;
  fret_t [NSTR-1:0]           fret_q, fret_d, enc_fret;
  logic [ENV_W-1:0]           env_q, env_d;
  logic [DC_W-1:0]            dcnt_q, dcnt_d;
  logic [TK_W-1:0]            tick_q, tick_d;
  logic                       swrite_q, swrite_d;
  logic signed [SAMPLE_W-1:0] sout_q, sout_d;
  logic signed [MIX_W-1:0]    mix, env_s;
  logic                       capture, tick, unused_bits;

  assign unused_bits = ^note_in[31:30];
  assign capture     = note_strobe && play_en;
  assign tick        = (tick_q == TK_W'(SAMPLE_DIV - 1));

  // Ascending scan so the highest fret pressed on each string wins.
  always_comb begin
    for (int s = 0; s < NSTR; s++) begin
      enc_fret[s] = '0;
      enc_act[s]  = 1'b0;
      for (int f = 0; f < NFRET; f++) begin
        if (note_in[NSTR*f + s]) begin
          enc_fret[s] = fret_t'(f);
          enc_act[s]  = 1'b1;
        end
      end
    end
  end

  for (genvar s = 0; s < NSTR; s++) begin : g_str
    string_osc u_osc (
      .clk         (clk),
      .resetn      (resetn),
      .clear       (capture),
      .enable      (active_q[s]),
      .half_period (HP_TAB[s][fret_q[s]]),
      .sq          (sq[s])
    );
  end

  always_comb begin
    env_s = $signed(MIX_W'(env_q));
    mix   = '0;
    for (int s = 0; s < NSTR; s++) begin
      if (active_q[s]) mix = sq[s] ? mix + env_s : mix - env_s;
    end
  end

  always_comb begin
    active_d = active_q;
    fret_d   = fret_q;
    env_d    = env_q;
    dcnt_d   = dcnt_q;
    tick_d   = tick ? '0 : tick_q + TK_W'(1);
    swrite_d = swrite_q;
    sout_d   = sout_q;
    if (!play_en) begin
      active_d = '0;
      env_d    = '0;
      dcnt_d   = '0;
    end else if (note_strobe) begin
      active_d = enc_act;
      fret_d   = enc_fret;
      env_d    = '1;
      dcnt_d   = '0;
    end else if (tick) begin
      if (dcnt_q == DC_W'(DECAY_DIV - 1)) begin
        dcnt_d = '0;
        if (env_q != '0) env_d = env_q - ENV_W'(1);
      end else begin
        dcnt_d = dcnt_q + DC_W'(1);
      end
    end
    // A fresh tick always wins over the transfer of the previous sample.
    if (tick) begin
      swrite_d = 1'b1;
      sout_d   = {mix, {(SAMPLE_W-MIX_W){1'b0}}};
    end else if (sample_ready) begin
      swrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active_q <= '0;
      fret_q   <= '0;
      env_q    <= '0;
      dcnt_q   <= '0;
      tick_q   <= '0;
      swrite_q <= 1'b0;
      sout_q   <= '0;
    end else begin
      active_q <= active_d;
      fret_q   <= fret_d;
      env_q    <= env_d;
      dcnt_q   <= dcnt_d;
      tick_q   <= tick_d;
      swrite_q <= swrite_d;
      sout_q   <= sout_d;
    end
  end

  assign active_strings = active_q;
  assign sample_write   = swrite_q;
  assign sample_out     = sout_q;

endmodule

// File: tb/tb_guitar_synth.sv
// Directed bench for guitar_synth at a reduced clock rate and short sample/decay dividers.
module tb_guitar_synth;

  localparam int SDIV = 8;
  localparam int DDIV = 2;

  logic               clk = 1'b0;
  logic               resetn;
  logic [31:0]        note_in;
  logic               note_strobe;
  logic               play_en;
  logic               sample_ready;
  logic               sample_write;
  logic signed [23:0] sample_out;
  logic [5:0]         active_strings;

  int checks = 0;
  int errors = 0;
  // Half periods at 500 kHz for each open string (E2 A2 D3 G3 B3 E4).
  int hp_cur [6] = '{3034, 2273, 1703, 1276, 1012, 758};
  logic signed [31:0] smp;

  guitar_synth #(
    .CLK_HZ     (500_000),
    .SAMPLE_DIV (SDIV),
    .DECAY_DIV  (DDIV)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .note_in        (note_in),
    .note_strobe    (note_strobe),
    .play_en        (play_en),
    .sample_ready   (sample_ready),
    .sample_write   (sample_write),
    .sample_out     (sample_out),
    .active_strings (active_strings)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_sample(output logic signed [31:0] s);
    bit seen;
    seen = 1'b0;
    s = 0;
    for (int i = 0; i < 4*SDIV && !seen; i++) begin
      @(negedge clk);
      if (sample_write) begin
        seen = 1'b1;
        s = $signed(sample_out);
      end
    end
    if (!seen) check_val("sample_timeout", 0, 1);
  endtask

  // Strobe is raised in a cycle where the tick counter is 0, so sample n is built
  // from the state SDIV*n-2 cycles after the oscillators start.
  task automatic do_strobe(input logic [31:0] note);
    note_in     = note;
    note_strobe = 1'b1;
    @(negedge clk);
    note_strobe = 1'b0;
  endtask

  function automatic int exp_smp(input int n, input logic [5:0] act);
    int env;
    int sum;
    env = 255 - (n - 1) / DDIV;
    if (env < 0) env = 0;
    sum = 0;
    for (int s = 0; s < 6; s++) begin
      if (act[s]) sum += (((SDIV*n - 2) / hp_cur[s]) % 2 == 0) ? env : -env;
    end
    return sum * 4096;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn       = 1'b0;
    note_in      = '0;
    note_strobe  = 1'b0;
    play_en      = 1'b1;
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_write", sample_write, 0);
    check_val("rst_out", sample_out, 0);
    check_val("rst_active", active_strings, 0);

    resetn = 1'b1;
    for (int i = 1; i < SDIV; i++) begin
      @(negedge clk);
      check_val("rst_wr_low", sample_write, 0);
    end
    @(negedge clk);
    check_val("first_tick_wr", sample_write, 1);
    check_val("first_tick_out", $signed(sample_out), 0);
    check_val("first_tick_act", active_strings, 0);
    @(negedge clk);
    check_val("pulse_fall", sample_write, 0);
    repeat (SDIV-1) @(negedge clk);
    check_val("pulse_period", sample_write, 1);

    // Open high E string.
    do_strobe(32'h20);
    check_val("open_active", active_strings, 6'b100000);
    for (int n = 1; n <= 100; n++) begin
      wait_sample(smp);
      check_val("open_model", smp, exp_smp(n, 6'b100000));
      if (n == 1)  check_val("open_first", smp, 1044480);
      if (n == 94) check_val("open_pre_toggle", smp, 856064);
      if (n == 95) check_val("open_post_toggle", smp, -851968);
    end

    // Fret 4 outranks the open bit on the same string.
    hp_cur[5] = 602;
    do_strobe(32'h2000_0020);
    check_val("fret_active", active_strings, 6'b100000);
    for (int n = 1; n <= 80; n++) begin
      wait_sample(smp);
      check_val("fret_model", smp, exp_smp(n, 6'b100000));
      if (n == 75) check_val("fret_pre_toggle", smp, 892928);
      if (n == 76) check_val("fret_post_toggle", smp, -892928);
    end
    hp_cur[5] = 758;

    do_strobe(32'h0);
    check_val("rest_active", active_strings, 0);
    for (int n = 1; n <= 3; n++) begin
      wait_sample(smp);
      check_val("rest_sample", smp, 0);
    end

    // Backpressure: strobe at cycle ts, now at ts+1.
    do_strobe(32'h20);
    sample_ready = 1'b0;
    repeat (7) @(negedge clk);
    check_val("bp_wr1", sample_write, 1);
    check_val("bp_out1", $signed(sample_out), 1044480);
    repeat (8) @(negedge clk);
    check_val("bp_wr2", sample_write, 1);
    check_val("bp_out2", $signed(sample_out), 1044480);
    repeat (8) @(negedge clk);
    check_val("bp_wr3", sample_write, 1);
    check_val("bp_out3", $signed(sample_out), 1040384);
    repeat (4) @(negedge clk);
    check_val("bp_hold", sample_write, 1);
    sample_ready = 1'b1;
    @(negedge clk);
    check_val("bp_drop", sample_write, 0);
    repeat (3) @(negedge clk);
    check_val("bp_next_wr", sample_write, 1);
    check_val("bp_next_out", $signed(sample_out), exp_smp(4, 6'b100000));

    // Playback gating mid-note.
    play_en = 1'b0;
    @(negedge clk);
    check_val("gate_active", active_strings, 0);
    for (int n = 1; n <= 3; n++) begin
      wait_sample(smp);
      check_val("gate_sample", smp, 0);
    end
    do_strobe(32'h3F);
    check_val("gate_strobe_act", active_strings, 0);
    wait_sample(smp);
    check_val("gate_strobe_smp", smp, 0);

    // Envelope decay with all six open strings.
    play_en = 1'b1;
    do_strobe(32'h3F);
    check_val("decay_active", active_strings, 6'h3F);
    for (int n = 1; n <= 515; n++) begin
      wait_sample(smp);
      check_val("decay_model", smp, exp_smp(n, 6'h3F));
      if (n == 1)   check_val("decay_first", smp, 6266880);
      if (n == 511) check_val("decay_zero", smp, 0);
    end
    check_val("decay_active_end", active_strings, 6'h3F);

    // Reset with a sample still pending.
    do_strobe(32'h3F);
    sample_ready = 1'b0;
    repeat (7) @(negedge clk);
    check_val("mid_pending", sample_write, 1);
    resetn = 1'b0;
    @(negedge clk);
    check_val("mid_rst_wr", sample_write, 0);
    check_val("mid_rst_out", sample_out, 0);
    check_val("mid_rst_act", active_strings, 0);
    resetn = 1'b1;
    sample_ready = 1'b1;
    repeat (SDIV) @(negedge clk);
    check_val("mid_rel_wr", sample_write, 1);
    check_val("mid_rel_out", $signed(sample_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
